// File: rtl/edge_fb_writer.sv
// edge_fb_writer: thresholds a raster Sobel magnitude stream into a
// column-major binary edge framebuffer, one frame per arm request.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-low reset
//   arm_in                  request capture of the next full frame
//   pixel_valid_in          qualifies hcount_in/vcount_in/mag_in
//   hcount_in, vcount_in    pixel column/row
//   mag_in, threshold_in    magnitude and edge threshold
//   fb_addr_out/data/we     framebuffer BRAM write port
//   busy_out                high while armed, capturing or flushing
//   frame_done_out          one-cycle pulse after the last write
//   edge_count_out          1-bits written in the last completed frame

module edge_fb_writer #(
    parameter int H_PIXELS  = 320,
    parameter int V_PIXELS  = 180,
    parameter int MAG_WIDTH = 8,
    parameter int FB_SIZE   = $clog2(H_PIXELS * V_PIXELS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 arm_in,
    input  logic                 pixel_valid_in,
    input  logic [8:0]           hcount_in,
    input  logic [7:0]           vcount_in,
    input  logic [MAG_WIDTH-1:0] mag_in,
    input  logic [MAG_WIDTH-1:0] threshold_in,
    output logic [FB_SIZE-1:0]   fb_addr_out,
    output logic                 fb_data_out,
    output logic                 fb_we_out,
    output logic                 busy_out,
    output logic                 frame_done_out,
    output logic [15:0]          edge_count_out
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FLUSH
    } state_t;

    localparam logic [8:0] H_LIM  = 9'(H_PIXELS);
    localparam logic [7:0] V_LIM  = 8'(V_PIXELS);
    localparam logic [8:0] H_LAST = 9'(H_PIXELS - 1);
    localparam logic [7:0] V_LAST = 8'(V_PIXELS - 1);

    // FSM and frame bookkeeping
    state_t               state_q;
    logic [1:0]           flush_q;
    logic                 busy_q;
    logic                 done_q;
    logic [MAG_WIDTH-1:0] thr_q;
    logic [15:0]          cnt_q;
    logic [15:0]          edge_count_q;

    // Stage 1: thresholded bit, column base address, row
    logic                 s1_valid_q;
    logic                 s1_bit_q;
    logic [FB_SIZE-1:0]   s1_hmul_q;
    logic [7:0]           s1_v_q;

    // Stage 2: BRAM write port
    logic                 fb_we_q;
    logic                 fb_data_q;
    logic [FB_SIZE-1:0]   fb_addr_q;

    // Combinational decode of the incoming pixel
    logic                 in_range;
    logic                 is_origin;
    logic                 is_last;
    logic                 accept;
    logic [MAG_WIDTH-1:0] thr_use;
    logic                 pix_bit;
    logic [FB_SIZE-1:0]   h_ext;
    logic [FB_SIZE-1:0]   h_mul;
    logic [15:0]          count_d;

    always_comb begin
        in_range  = pixel_valid_in
                  && (hcount_in < H_LIM)
                  && (vcount_in < V_LIM);
        is_origin = (hcount_in == '0) && (vcount_in == '0);
        is_last   = (hcount_in == H_LAST) && (vcount_in == V_LAST);

        // Only the origin pixel can start a frame; once started,
        // every in-range valid pixel is written.
        accept = in_range
               && ((state_q == CAPTURE)
                   || ((state_q == ARMED) && is_origin));

        // The origin pixel sees the live threshold because the
        // latch happens on the same edge that consumes it.
        thr_use = (state_q == ARMED) ? threshold_in : thr_q;
        pix_bit = (mag_in >= thr_use);

        // h * 180 = h*128 + h*32 + h*16 + h*4
        h_ext = FB_SIZE'(hcount_in);
        h_mul = (h_ext << 7) + (h_ext << 5)
              + (h_ext << 4) + (h_ext << 2);

        // Includes the write currently on the BRAM port so the
        // snapshot taken at the end of FLUSH sees the last pixel.
        count_d = cnt_q + 16'(fb_we_q & fb_data_q);
    end

    // Two-stage write pipeline
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid_q <= 1'b0;
            s1_bit_q   <= 1'b0;
            s1_hmul_q  <= '0;
            s1_v_q     <= '0;
            fb_we_q    <= 1'b0;
            fb_data_q  <= 1'b0;
            fb_addr_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_bit_q  <= pix_bit;
                s1_hmul_q <= h_mul;
                s1_v_q    <= vcount_in;
            end

            fb_we_q <= s1_valid_q;
            if (s1_valid_q) begin
                fb_data_q <= s1_bit_q;
                fb_addr_q <= s1_hmul_q + FB_SIZE'(s1_v_q);
            end
        end
    end

    // Capture FSM with registered status outputs
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            flush_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            thr_q        <= '0;
            cnt_q        <= '0;
            edge_count_q <= '0;
        end else begin
            if ((state_q == ARMED) && accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= count_d;
            end

            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (arm_in) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end

                ARMED: begin
                    if (accept) begin
                        thr_q   <= threshold_in;
                        state_q <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (accept && is_last) begin
                        state_q <= FLUSH;
                        flush_q <= '0;
                    end
                end

                FLUSH: begin
                    // flush_q 0: last pixel in stage 1
                    // flush_q 1: last pixel on the BRAM port
                    // flush_q 2: frame_done_out cycle
                    flush_q <= flush_q + 2'd1;
                    if (flush_q == 2'd1) begin
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        edge_count_q <= count_d;
                    end
                    if (flush_q == 2'd2) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fb_addr_out    = fb_addr_q;
    assign fb_data_out    = fb_data_q;
    assign fb_we_out      = fb_we_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;
    assign edge_count_out = edge_count_q;

endmodule

// File: tb/tb_edge_fb_writer.sv
// tb_edge_fb_writer: directed bench for edge_fb_writer.
// A negedge monitor records writes; one initial block drives and checks.

module tb_edge_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        pv;
    logic [8:0]  hc;
    logic [7:0]  vc;
    logic [7:0]  mag;
    logic [7:0]  thr;
    logic [15:0] addr;
    logic        data;
    logic        we;
    logic        busy;
    logic        done;
    logic [15:0] ecnt;

    always #5 clk = ~clk;

    edge_fb_writer dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .arm_in         (arm),
        .pixel_valid_in (pv),
        .hcount_in      (hc),
        .vcount_in      (vc),
        .mag_in         (mag),
        .threshold_in   (thr),
        .fb_addr_out    (addr),
        .fb_data_out    (data),
        .fb_we_out      (we),
        .busy_out       (busy),
        .frame_done_out (done),
        .edge_count_out (ecnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor
    logic fbm [0:57599];
    logic clr = 1'b0;
    int   n_we, n_ones, n_done, busy_seen;
    int   first_addr, first_cyc, done_cyc, last_we_cyc, last_addr;
    logic busy_at_done;

    always @(negedge clk) begin
        if (clr) begin
            n_we = 0;
            n_ones = 0;
            n_done = 0;
            busy_seen = 0;
            first_addr = -1;
            first_cyc = -1;
            done_cyc = -1;
            last_we_cyc = -1;
            last_addr = -1;
            busy_at_done = 1'bx;
            for (int i = 0; i < 57600; i++) fbm[i] = 1'bx;
        end else begin
            if (we === 1'b1) begin
                if (n_we == 0) begin
                    first_addr = int'(addr);
                    first_cyc = cyc;
                end
                n_we++;
                if (data === 1'b1) n_ones++;
                if (addr < 16'd57600) fbm[addr] = data;
                last_we_cyc = cyc;
                last_addr = int'(addr);
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (busy === 1'b1) busy_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic px(input int h, input int v, input int m,
                      input bit val);
        pv  = val;
        hc  = 9'(h);
        vc  = 8'(v);
        mag = 8'(m);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pv = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        idle(1);
        arm = 1'b0;
    endtask

    int t;
    int t0;

    initial begin
        rst_n = 1'b0;
        arm = 1'b0;
        pv = 1'b0;
        hc = '0;
        vc = '0;
        mag = '0;
        thr = '0;
        idle(3);

        // Reset state
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ecnt", ecnt, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;
        idle(2);

        // A: full raster frame, edges on column 10
        thr = 8'd64;
        clr_mon();
        arm_pulse();
        chk("A_busy_armed", busy, 1);
        t = 0;
        for (int v = 0; v < 180; v++) begin
            for (int h = 0; h < 320; h++) begin
                if (h == 319 && v == 179) t = cyc;
                px(h, v, (h == 10) ? 200 : 0, 1'b1);
            end
        end
        idle(2);
        chk("A_done_T3", done, 1);
        chk("A_busy_T3", busy, 0);
        chk("A_ecnt_T3", ecnt, 180);
        idle(1);
        chk("A_done_T4", done, 0);
        idle(3);
        chk("A_nwe", n_we, 57600);
        chk("A_ones", n_ones, 180);
        chk("A_fb1805", fbm[1805], 1);
        chk("A_fb1806", fbm[1806], 1);
        chk("A_fb1985", fbm[1985], 0);
        chk("A_fb0", fbm[0], 0);
        chk("A_ndone", n_done, 1);
        chk("A_done_cyc", done_cyc, t + 3);
        chk("A_last_we_cyc", last_we_cyc, t + 2);
        chk("A_last_addr", last_addr, 57599);
        chk("A_busy_at_done", busy_at_done, 0);
        chk("A_ecnt_hold", ecnt, 180);

        // B: no arm, then arm mid-frame
        clr_mon();
        px(0, 0, 200, 1'b1);
        px(5, 5, 200, 1'b1);
        px(319, 179, 200, 1'b1);
        idle(3);
        chk("B_noarm_we", n_we, 0);
        chk("B_noarm_busy", busy_seen, 0);
        px(0, 1, 200, 1'b1);
        arm = 1'b1;
        px(2, 1, 200, 1'b1);
        arm = 1'b0;
        px(3, 1, 200, 1'b1);
        px(319, 179, 200, 1'b1);
        t0 = cyc;
        px(0, 0, 200, 1'b1);
        px(1, 0, 0, 1'b1);
        px(319, 179, 200, 1'b1);
        idle(4);
        chk("B_first_addr", first_addr, 0);
        chk("B_first_cyc", first_cyc, t0 + 2);
        chk("B_nwe", n_we, 3);
        chk("B_fb180", fbm[180], 0);
        chk("B_ecnt", ecnt, 2);
        chk("B_ndone", n_done, 1);

        // C: threshold compare, live at origin, latched afterwards
        thr = 8'd100;
        clr_mon();
        arm_pulse();
        px(0, 0, 99, 1'b1);
        px(0, 1, 100, 1'b1);
        px(0, 2, 99, 1'b1);
        thr = 8'd255;
        px(1, 0, 100, 1'b1);
        px(319, 179, 100, 1'b1);
        idle(4);
        chk("C_fb0", fbm[0], 0);
        chk("C_fb1", fbm[1], 1);
        chk("C_fb2", fbm[2], 0);
        chk("C_fb180", fbm[180], 1);
        chk("C_fb57599", fbm[57599], 1);
        chk("C_ecnt", ecnt, 3);

        // D: gaps and out-of-range pixels
        thr = 8'd64;
        clr_mon();
        arm_pulse();
        px(0, 0, 200, 1'b1);
        px(5, 5, 200, 1'b0);
        px(1, 1, 200, 1'b1);
        px(320, 0, 200, 1'b1);
        px(5, 200, 200, 1'b1);
        t = cyc;
        px(2, 2, 200, 1'b1);
        px(319, 179, 200, 1'b1);
        chk("D_we_T2", we, 1);
        chk("D_addr_T2", addr, 362);
        idle(4);
        chk("D_nwe", n_we, 4);
        chk("D_fb181", fbm[181], 1);
        chk("D_ndone", n_done, 1);
        chk("D_done_cyc", done_cyc, t + 4);
        chk("D_ecnt", ecnt, 4);

        // E: reset mid-capture, then re-arm
        clr_mon();
        arm_pulse();
        px(0, 0, 200, 1'b1);
        px(50, 50, 200, 1'b1);
        rst_n = 1'b0;
        px(100, 50, 200, 1'b1);
        rst_n = 1'b1;
        chk("E_we_after_rst", we, 0);
        chk("E_busy_after_rst", busy, 0);
        px(101, 50, 200, 1'b1);
        px(319, 179, 200, 1'b1);
        idle(4);
        chk("E_nwe", n_we, 1);
        chk("E_ndone", n_done, 0);
        chk("E_ecnt", ecnt, 0);
        arm_pulse();
        px(0, 0, 200, 1'b1);
        px(319, 179, 200, 1'b1);
        idle(4);
        chk("E_rearm_ecnt", ecnt, 2);
        chk("E_rearm_ndone", n_done, 1);

        // F: arm during CAPTURE and in the done cycle
        clr_mon();
        arm_pulse();
        px(0, 0, 200, 1'b1);
        arm = 1'b1;
        px(1, 0, 200, 1'b1);
        arm = 1'b0;
        px(319, 179, 0, 1'b1);
        idle(2);
        chk("F_done", done, 1);
        arm = 1'b1;
        idle(1);
        arm = 1'b0;
        px(0, 0, 200, 1'b1);
        px(319, 179, 200, 1'b1);
        idle(3);
        chk("F_busy_idle", busy, 0);
        chk("F_nwe", n_we, 3);
        chk("F_ndone", n_done, 1);
        chk("F_ecnt1", ecnt, 2);
        arm_pulse();
        px(0, 0, 200, 1'b1);
        px(3, 3, 200, 1'b1);
        chk("F_ecnt_hold", ecnt, 2);
        px(7, 7, 200, 1'b1);
        px(319, 179, 0, 1'b1);
        idle(4);
        chk("F_ecnt2", ecnt, 3);
        chk("F_ndone2", n_done, 2);
        chk("F_nwe2", n_we, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
